// File: rtl/hdp_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : hdp_stream_if
// Description : Ciphertext-in / pixel-out handshake bundle for hdp_stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface hdp_stream_if;
    logic [19:0] ciphertext;
    logic        ct_valid;
    logic        ct_ready;
    logic [7:0]  pixel_byte;
    logic        px_valid;
    logic        px_ready;
    logic        noise_flag;

    // Upstream/downstream side that feeds ciphertexts and consumes pixels
    modport master (
        output ciphertext, ct_valid, px_ready,
        input  ct_ready, pixel_byte, px_valid, noise_flag
    );

    // Decryptor side
    modport slave (
        input  ciphertext, ct_valid, px_ready,
        output ct_ready, pixel_byte, px_valid, noise_flag
    );
endinterface
`default_nettype wire

// File: rtl/hdp_stream.sv
`default_nettype none
// ============================================================================
// Module      : hdp_stream
// Description : Serial LWE-style pixel decryptor: b - a*s mod 1024, rounded /4.
// Revision    : 1.0 - initial release
// ============================================================================
module hdp_stream #(
    parameter int SECRET_KEY = 7
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hdp_stream_if.slave      bus,
    output logic [15:0]      decrypt_count
);

    localparam logic [2:0] c_KEY  = 3'(SECRET_KEY);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_SUB  = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    logic [1:0]  r_state,    w_state_nxt;
    logic [9:0]  r_a,        w_a_nxt;
    logic [9:0]  r_b,        w_b_nxt;
    logic [9:0]  r_acc,      w_acc_nxt;
    logic [1:0]  r_bit,      w_bit_nxt;
    logic [7:0]  r_pixel,    w_pixel_nxt;
    logic        r_noise,    w_noise_nxt;
    logic        r_px_valid, w_px_valid_nxt;
    logic [15:0] r_count,    w_count_nxt;

    logic [9:0]  w_diff;
    logic [9:0]  w_diff_rnd;
    logic [7:0]  w_pixel;

    // The 10-bit wrap of diff+2 folds diff >= 1022 onto pixel 0, matching mod 256.
    assign w_diff     = r_b - r_acc;
    assign w_diff_rnd = w_diff + 10'd2;
    assign w_pixel    = 8'(w_diff_rnd >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_bit      <= '0;
            r_pixel    <= '0;
            r_noise    <= 1'b0;
            r_px_valid <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_acc      <= w_acc_nxt;
            r_bit      <= w_bit_nxt;
            r_pixel    <= w_pixel_nxt;
            r_noise    <= w_noise_nxt;
            r_px_valid <= w_px_valid_nxt;
            r_count    <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_acc_nxt      = r_acc;
        w_bit_nxt      = r_bit;
        w_pixel_nxt    = r_pixel;
        w_noise_nxt    = r_noise;
        w_px_valid_nxt = r_px_valid;
        w_count_nxt    = r_count;

        case (r_state)
            c_IDLE: begin
                if (bus.ct_valid) begin
                    w_a_nxt     = bus.ciphertext[19:10];
                    w_b_nxt     = bus.ciphertext[9:0];
                    w_acc_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_MUL;
                end
            end
            c_MUL: begin
                // One key bit per cycle, LSB first; shifted operand wraps at 10 bits.
                if (c_KEY[r_bit]) begin
                    w_acc_nxt = r_acc + (r_a << r_bit);
                end
                w_bit_nxt = 2'(r_bit + 2'd1);
                if (r_bit == 2'd2) begin
                    w_state_nxt = c_SUB;
                end
            end
            c_SUB: begin
                w_pixel_nxt    = w_pixel;
                w_noise_nxt    = (w_diff[1:0] == 2'b10);
                w_px_valid_nxt = 1'b1;
                w_state_nxt    = c_OUT;
            end
            c_OUT: begin
                if (bus.px_ready) begin
                    w_px_valid_nxt = 1'b0;
                    w_count_nxt    = r_count + 16'd1;
                    w_state_nxt    = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign bus.ct_ready   = (r_state == c_IDLE);
    assign bus.pixel_byte = r_pixel;
    assign bus.noise_flag = r_noise;
    assign bus.px_valid   = r_px_valid;
    assign decrypt_count  = r_count;

endmodule
`default_nettype wire
